// File: rtl/swervolf_pkg.sv
// Shared definitions for the switch/button input debounce peripheral:
// register offsets, counter width and a byte-enable helper.
package swervolf_pkg;

  // Width of the per-input stability counter (holds up to 15 ticks).
  localparam int CNT_W = 4;

  // Word offsets (byte address bits [4:2]) of the peripheral registers.
  localparam logic [2:0] ADR_STATE = 3'd0;
  localparam logic [2:0] ADR_RISE  = 3'd1;
  localparam logic [2:0] ADR_FALL  = 3'd2;
  localparam logic [2:0] ADR_IRQEN = 3'd3;
  localparam logic [2:0] ADR_RAW   = 3'd4;

  // Expand the four Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/swervolf_debounce_bit.sv
// One debounced input: two-flop synchroniser, tick-based stability counter
// and the accepted (debounced) state. Emits single-cycle rise/fall pulses in
// the cycle a change is accepted, so the register file can set its sticky
// flags on the same clock edge that updates the state.
module swervolf_debounce_bit
  import swervolf_pkg::*;
#(
  parameter int STABLE_TICKS = 8
) (
  input  logic clk_core,
  input  logic rstn,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_sync,
  output logic o_state,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [1:0]       r_sync;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_accept;

  // Bring the asynchronous pin into the clk_core domain.
  always_ff @(posedge clk_core or negedge rstn) begin
    // NOTE: non-blocking so both stages sample the pre-edge values and the
    // chain really is two flops deep.
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

  assign w_differ = r_sync[1] ^ r_state;
  assign w_accept = w_differ & i_tick & (r_cnt == CNT_LAST);

  // Count ticks during which the synchronised input disagrees with the
  // debounced state; any return to agreement restarts the count.
  always_ff @(posedge clk_core or negedge rstn) begin
    // NOTE: every flop in this peripheral is a control/status register, so
    // all of them take the asynchronous reset; there is no storage array
    // that could be left unreset.
    if (!rstn) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else if (!w_differ) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (r_cnt == CNT_LAST) begin
        r_state <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sync  = r_sync[1];
  assign o_state = r_state;
  assign o_rise  = w_accept &  r_sync[1];
  assign o_fall  = w_accept & ~r_sync[1];

endmodule

// File: rtl/swervolf_input_debounce.sv
// Switch/button input peripheral: shared debounce prescaler, one debounce
// slice per input, sticky edge registers, an interrupt mask and a 32-bit
// Wishbone classic responder for CPU access.
module swervolf_input_debounce
  import swervolf_pkg::*;
#(
  parameter int N_IN         = 21,
  parameter int PRESCALE     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic            clk_core,
  input  logic            rstn,
  input  logic [N_IN-1:0] i_in,
  input  logic [4:0]      i_wb_adr,
  input  logic [31:0]     i_wb_dat,
  input  logic [3:0]      i_wb_sel,
  input  logic            i_wb_we,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  output logic [31:0]     o_wb_rdt,
  output logic            o_wb_ack,
  output logic            o_irq
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  // Prescaler
  logic [PW-1:0]   r_presc;
  logic            w_tick;

  // Debounce slices
  logic [N_IN-1:0] w_sync;
  logic [N_IN-1:0] w_state;
  logic [N_IN-1:0] w_rise_p;
  logic [N_IN-1:0] w_fall_p;

  // Register file
  logic [N_IN-1:0] r_rise;
  logic [N_IN-1:0] r_fall;
  logic [N_IN-1:0] r_irqen;

  // Bus interface
  logic            r_ack;
  logic [31:0]     r_rdt;
  logic            r_irq;
  logic [2:0]      w_reg_sel;
  logic            w_access;
  logic            w_wr;
  logic [31:0]     w_byte_mask;
  logic [31:0]     w_wr_data;
  logic [N_IN-1:0] w_clr_rise;
  logic [N_IN-1:0] w_clr_fall;
  logic [31:0]     w_rd_data;
  logic            w_unused;

  // Free-running divider producing one tick every PRESCALE cycles.
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_tick = (r_presc == PRESC_LAST);

  for (genvar g = 0; g < N_IN; g++) begin : g_bit
    swervolf_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk_core(clk_core),
      .rstn    (rstn),
      .i_raw   (i_in[g]),
      .i_tick  (w_tick),
      .o_sync  (w_sync[g]),
      .o_state (w_state[g]),
      .o_rise  (w_rise_p[g]),
      .o_fall  (w_fall_p[g])
    );
  end

  // A new access is one the responder has not yet acknowledged; the write
  // commits on the same edge that raises ack.
  assign w_reg_sel   = i_wb_adr[4:2];
  assign w_access    = i_wb_cyc & i_wb_stb & ~r_ack;
  assign w_wr        = w_access & i_wb_we;
  assign w_byte_mask = byte_mask(i_wb_sel);
  assign w_wr_data   = i_wb_dat & w_byte_mask;
  assign w_clr_rise  = (w_wr && (w_reg_sel == ADR_RISE)) ? w_wr_data[N_IN-1:0] : '0;
  assign w_clr_fall  = (w_wr && (w_reg_sel == ADR_FALL)) ? w_wr_data[N_IN-1:0] : '0;

  // Byte-address bits and data bits above N_IN carry no information here.
  assign w_unused = ^{i_wb_adr[1:0], w_wr_data};

  // Sticky edge flags: write-1-to-clear, with a same-cycle new edge winning.
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= (r_rise & ~w_clr_rise) | w_rise_p;
      r_fall <= (r_fall & ~w_clr_fall) | w_fall_p;
    end
  end

  // Interrupt mask, updated byte-wise under the byte selects.
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      r_irqen <= '0;
    end else if (w_wr && (w_reg_sel == ADR_IRQEN)) begin
      r_irqen <= (r_irqen & ~w_byte_mask[N_IN-1:0]) | w_wr_data[N_IN-1:0];
    end
  end

  // Read multiplexer, zero-extended to the bus width.
  always_comb begin
    // NOTE: default first so every path assigns w_rd_data and no latch forms;
    // unmapped offsets fall through to zero.
    w_rd_data = '0;
    case (w_reg_sel)
      ADR_STATE: w_rd_data = 32'(w_state);
      ADR_RISE:  w_rd_data = 32'(r_rise);
      ADR_FALL:  w_rd_data = 32'(r_fall);
      ADR_IRQEN: w_rd_data = 32'(r_irqen);
      ADR_RAW:   w_rd_data = 32'(w_sync);
      default:   w_rd_data = '0;
    endcase
  end

  // Single-cycle acknowledge with read data captured alongside it and held.
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
    end else begin
      r_ack <= i_wb_cyc & i_wb_stb & ~r_ack;
      if (w_access) begin
        r_rdt <= w_rd_data;
      end
    end
  end

  // Level interrupt for any enabled pending edge.
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |((r_rise | r_fall) & r_irqen);
    end
  end

  assign o_wb_ack = r_ack;
  assign o_wb_rdt = r_rdt;
  assign o_irq    = r_irq;

endmodule

// File: tb/tb_swervolf_input_debounce.sv
// Bench for the input debounce peripheral. Bus stimulus pushes the expected
// response into a scoreboard queue; a monitor pops and compares on each ack.
module tb_swervolf_input_debounce;

  localparam int N_IN         = 21;
  localparam int PRESCALE     = 4;
  localparam int STABLE_TICKS = 3;

  logic            clk_core = 1'b0;
  logic            rstn     = 1'b0;
  logic [N_IN-1:0] i_in     = '0;
  logic [4:0]      i_wb_adr = '0;
  logic [31:0]     i_wb_dat = '0;
  logic [3:0]      i_wb_sel = '0;
  logic            i_wb_we  = 1'b0;
  logic            i_wb_cyc = 1'b0;
  logic            i_wb_stb = 1'b0;
  logic [31:0]     o_wb_rdt;
  logic            o_wb_ack;
  logic            o_irq;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_n;

  swervolf_input_debounce #(
    .N_IN        (N_IN),
    .PRESCALE    (PRESCALE),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk_core(clk_core),
    .rstn    (rstn),
    .i_in    (i_in),
    .i_wb_adr(i_wb_adr),
    .i_wb_dat(i_wb_dat),
    .i_wb_sel(i_wb_sel),
    .i_wb_we (i_wb_we),
    .i_wb_cyc(i_wb_cyc),
    .i_wb_stb(i_wb_stb),
    .o_wb_rdt(o_wb_rdt),
    .o_wb_ack(o_wb_ack),
    .o_irq   (o_irq)
  );

  always #5 clk_core = ~clk_core;

  // Edge index since reset release: edge 1 is the first posedge with rstn high.
  always @(posedge clk_core or negedge rstn) begin
    if (!rstn) cyc_n <= 0;
    else       cyc_n <= cyc_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk_core) begin : monitor
    exp_t e;
    if (o_wb_ack) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {31'b0, o_wb_ack}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.is_read) check(e.name, o_wb_rdt, e.data);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  // One Wishbone access; called at #1 after a clock edge.
  task automatic wb_access(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp, input string name);
    int   lat = 0;
    exp_t e;
    if (o_wb_ack) begin
      @(posedge clk_core);
      #1;
    end
    e.is_read = !we;
    e.data    = exp;
    e.name    = name;
    sb_q.push_back(e);
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = we;
    i_wb_adr = adr;
    i_wb_dat = dat;
    i_wb_sel = sel;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_core);
      #1;
      if (o_wb_ack) begin
        lat = k;
        break;
      end
    end
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
    check({name, "_ack_latency"}, 32'(lat), 32'd1);
    if (lat == 0) void'(sb_q.pop_back());
  endtask

  task automatic wb_read(input logic [4:0] adr, input logic [31:0] exp, input string name);
    wb_access(1'b0, adr, 32'd0, 4'hF, exp, name);
  endtask

  task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input string name);
    wb_access(1'b1, adr, dat, sel, 32'd0, name);
  endtask

  // Edge at which a change driven just after edge n0 is accepted: sync is
  // valid for edges >= n0+3, ticks fall on edges divisible by PRESCALE, and
  // the change lands on the STABLE_TICKS-th tick.
  function automatic int accept_edge(input int n0);
    int t = n0 + 3;
    while ((t % PRESCALE) != 0) t++;
    return t + PRESCALE * (STABLE_TICKS - 1);
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n0;
    int acc;

    // Reset state
    repeat (3) @(posedge clk_core);
    #1;
    rstn = 1'b1;
    wait_cycles(1);
    check("irq_reset", {31'b0, o_irq}, 32'd0);
    wb_read(5'h00, 32'h0, "state_reset");
    wb_read(5'h04, 32'h0, "rise_reset");
    wb_read(5'h08, 32'h0, "fall_reset");
    wb_read(5'h0C, 32'h0, "irqen_reset");
    wb_read(5'h10, 32'h0, "raw_reset");

    // Clean rise on bit 0
    i_in[0] = 1'b1;
    wait_cycles(3);
    wb_read(5'h10, 32'h1, "raw_after_sync");
    wb_read(5'h00, 32'h0, "state_before_accept");
    wait_cycles(20);
    wb_read(5'h00, 32'h1, "state_rise0");
    wb_read(5'h04, 32'h1, "rise_rise0");
    wb_read(5'h08, 32'h0, "fall_rise0");

    // Bit 5 glitches: 6 cycles high, 6 low, five times
    for (int r = 0; r < 5; r++) begin
      i_in[5] = 1'b1;
      wait_cycles(6);
      i_in[5] = 1'b0;
      wait_cycles(6);
    end
    wait_cycles(12);
    wb_read(5'h00, 32'h1, "state_glitch");
    wb_read(5'h04, 32'h1, "rise_glitch");
    wb_read(5'h08, 32'h0, "fall_glitch");

    // W1C, then fall on bit 0 and rise on bit 1
    wb_write(5'h04, 32'h1, 4'hF, "w1c_rise0");
    wb_read(5'h04, 32'h0, "rise_cleared");
    i_in[0] = 1'b0;
    i_in[1] = 1'b1;
    wait_cycles(20);
    wb_read(5'h00, 32'h2, "state_fall0_rise1");
    wb_read(5'h04, 32'h2, "rise_bit1");
    wb_read(5'h08, 32'h1, "fall_bit0");
    wb_write(5'h04, 32'h2, 4'hF, "w1c_rise1");
    wb_write(5'h08, 32'h1, 4'hF, "w1c_fall0");
    wb_read(5'h04, 32'h0, "rise_clear_all");
    wb_read(5'h08, 32'h0, "fall_clear_all");

    // Interrupt on a debounced rise of bit 0, exact timing
    wb_write(5'h0C, 32'h1, 4'hF, "irqen_set");
    wb_read(5'h0C, 32'h1, "irqen_readback");
    check("irq_idle", {31'b0, o_irq}, 32'd0);
    n0 = cyc_n;
    i_in[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_core);
      #1;
      if (o_irq) break;
    end
    check("irq_rise_edge", 32'(cyc_n), 32'(accept_edge(n0) + 1));
    wb_read(5'h04, 32'h1, "rise_with_irq");
    wb_write(5'h04, 32'h1, 4'hF, "w1c_irq");
    check("irq_hold_at_ack", {31'b0, o_irq}, 32'd1);
    wait_cycles(1);
    check("irq_drop_after_w1c", {31'b0, o_irq}, 32'd0);
    wb_read(5'h04, 32'h0, "rise_after_w1c");

    // Interrupt masking via IRQ_EN
    i_in[0] = 1'b0;
    i_in[3] = 1'b1;
    wait_cycles(20);
    wb_read(5'h00, 32'hA, "state_fall0_rise3");
    wb_read(5'h04, 32'h8, "rise_bit3");
    wb_read(5'h08, 32'h1, "fall_bit0_again");
    check("irq_on_fall", {31'b0, o_irq}, 32'd1);
    wb_write(5'h0C, 32'h0, 4'hF, "irqen_mask");
    check("irq_hold_at_mask", {31'b0, o_irq}, 32'd1);
    wait_cycles(1);
    check("irq_masked", {31'b0, o_irq}, 32'd0);
    wb_write(5'h08, 32'h1, 4'hF, "w1c_fall0_again");

    // W1C lands on the same edge as a new rise of bit 0; bit 3 still clears
    n0 = cyc_n;
    i_in[0] = 1'b1;
    acc = accept_edge(n0);
    while (cyc_n < acc - 1) begin
      @(posedge clk_core);
      #1;
    end
    wb_write(5'h04, 32'h9, 4'hF, "w1c_conflict");
    wb_read(5'h04, 32'h1, "rise_edge_wins");
    wb_read(5'h00, 32'hB, "state_after_conflict");
    wb_write(5'h04, 32'h1, 4'hF, "w1c_rise0_final");
    wb_read(5'h04, 32'h0, "rise_empty");

    // Bus corner cases
    wb_read(5'h14, 32'h0, "read_0x14");
    wb_read(5'h18, 32'h0, "read_0x18");
    wb_read(5'h1C, 32'h0, "read_0x1c");
    wb_write(5'h00, 32'hFFFF_FFFF, 4'hF, "write_state");
    wb_read(5'h00, 32'hB, "state_ro");
    wb_write(5'h10, 32'hFFFF_FFFF, 4'hF, "write_raw");
    wb_read(5'h10, 32'hB, "raw_ro");
    wb_write(5'h0C, 32'hFFFF_FFFF, 4'b0001, "irqen_sel0");
    wb_read(5'h0C, 32'h0000_00FF, "irqen_byte0");
    wb_write(5'h0C, 32'h0000_AB00, 4'b0110, "irqen_sel12");
    wb_read(5'h0C, 32'h0000_ABFF, "irqen_bytes12");
    wb_write(5'h0C, 32'hFFFF_FFFF, 4'hF, "irqen_all");
    wb_read(5'h0C, 32'h001F_FFFF, "irqen_zero_ext");
    wb_write(5'h0C, 32'h0, 4'hF, "irqen_clear");

    // Reset mid-count with a strobe pending
    i_in[2] = 1'b1;
    wait_cycles(6);
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b1;
    i_wb_adr = 5'h0C;
    i_wb_dat = 32'hFF;
    i_wb_sel = 4'hF;
    #2;
    rstn = 1'b0;
    wait_cycles(3);
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
    check("ack_in_reset", {31'b0, o_wb_ack}, 32'd0);
    check("irq_in_reset", {31'b0, o_irq}, 32'd0);
    rstn = 1'b1;
    wait_cycles(1);
    check("ack_after_reset", {31'b0, o_wb_ack}, 32'd0);
    wb_read(5'h00, 32'h0, "state_after_reset");
    wb_read(5'h04, 32'h0, "rise_after_reset");
    wb_read(5'h08, 32'h0, "fall_after_reset");
    wb_read(5'h0C, 32'h0, "irqen_after_reset");
    wb_read(5'h10, 32'hF, "raw_after_reset");
    wait_cycles(20);
    wb_read(5'h00, 32'hF, "state_redebounce");
    wb_read(5'h04, 32'hF, "rise_redebounce");
    wb_read(5'h08, 32'h0, "fall_redebounce");

    wait_cycles(3);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
